// File: rtl/segre_pkg.sv
// Shared definitions for the segre dcache / MMU slice.
//  - Dcache geometry: lane width, index width, byte-offset width.
//  - State encoding of the MMU-side miss controller.
//  - Source select for the miss controller's lane buffer.
package segre_pkg;

   localparam int DCACHE_LANE_SIZE  = 128;  // bits per lane
   localparam int DCACHE_INDEX_SIZE = 6;    // lanes in the array = 2**index
   localparam int DCACHE_BYTE_SIZE  = 4;    // log2(bytes per lane)

   typedef enum logic [2:0] {
      IDLE,
      WB_REQ,
      RD_REQ,
      RD_WAIT,
      FILL
   } mmu_dcache_state_e;

   typedef enum logic {
      LANE_SRC_VICTIM,
      LANE_SRC_MEM
   } lane_src_e;

endpackage

// File: rtl/segre_mmu_lane_buffer.sv
// Single-lane holding register for the miss controller.
// It first holds the victim lane (for writeback) and is later overwritten
// with the lane read from memory (for the fill).
// Ports:
//  clk_i          clock
//  rsn_i          asynchronous active-low reset (clears contents)
//  load_i         load enable
//  sel_i          source select: victim lane or memory read data
//  victim_data_i  victim lane from the data array
//  mem_data_i     lane returned by memory
//  data_o         current buffer contents
import segre_pkg::*;

module segre_mmu_lane_buffer #(
   parameter int LANE_SIZE = DCACHE_LANE_SIZE
) (
   input  logic                 clk_i,
   input  logic                 rsn_i,
   input  logic                 load_i,
   input  lane_src_e            sel_i,
   input  logic [LANE_SIZE-1:0] victim_data_i,
   input  logic [LANE_SIZE-1:0] mem_data_i,
   output logic [LANE_SIZE-1:0] data_o
);

   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         data_o <= '0;
      end else if (load_i) begin
         data_o <= (sel_i == LANE_SRC_MEM) ? mem_data_i : victim_data_i;
      end
   end

endmodule

// File: rtl/segre_mmu_dcache_ctrl.sv
// MMU-side dcache miss controller.
// On a miss it captures the missing address and the victim lane, writes the
// victim back to memory if dirty, reads the missing lane and then issues a
// one-cycle fill strobe into the dcache data/tag arrays. One miss at a time.
// Ports:
//  clk_i, rsn_i        clock, asynchronous active-low reset
//  miss_i              miss request level (sampled only when idle)
//  miss_addr_i         byte address that missed
//  victim_dirty_i      victim lane dirty flag
//  victim_addr_i       byte address of the victim lane
//  victim_data_i       victim lane contents
//  busy_o              miss in progress, cache stalls
//  mmu_wr_data_o       fill strobe (one cycle)
//  mmu_index_o         index of the lane being filled
//  mmu_data_o          fill data
//  mem_wr_o, mem_rd_o  memory requests, held until mem_ready_i
//  mem_addr_o          lane-aligned memory address
//  mem_data_o          writeback data
//  mem_ready_i         memory accepts current request
//  mem_rvalid_i        read data valid
//  mem_rdata_i         read data
//  miss_cnt_o          serviced misses (saturating)
//  wb_cnt_o            dirty writebacks (saturating)
import segre_pkg::*;

module segre_mmu_dcache_ctrl #(
   parameter int ADDR_SIZE  = 32,
   parameter int LANE_SIZE  = DCACHE_LANE_SIZE,
   parameter int INDEX_SIZE = DCACHE_INDEX_SIZE,
   parameter int CNT_SIZE   = 32
) (
   input  logic                  clk_i,
   input  logic                  rsn_i,
   input  logic                  miss_i,
   input  logic [ADDR_SIZE-1:0]  miss_addr_i,
   input  logic                  victim_dirty_i,
   input  logic [ADDR_SIZE-1:0]  victim_addr_i,
   input  logic [LANE_SIZE-1:0]  victim_data_i,
   output logic                  busy_o,
   output logic                  mmu_wr_data_o,
   output logic [INDEX_SIZE-1:0] mmu_index_o,
   output logic [LANE_SIZE-1:0]  mmu_data_o,
   output logic                  mem_wr_o,
   output logic                  mem_rd_o,
   output logic [ADDR_SIZE-1:0]  mem_addr_o,
   output logic [LANE_SIZE-1:0]  mem_data_o,
   input  logic                  mem_ready_i,
   input  logic                  mem_rvalid_i,
   input  logic [LANE_SIZE-1:0]  mem_rdata_i,
   output logic [CNT_SIZE-1:0]   miss_cnt_o,
   output logic [CNT_SIZE-1:0]   wb_cnt_o
);

   // Byte-offset bits within a lane; the index field sits right above them.
   localparam int OFF_SIZE = $clog2(LANE_SIZE / 8);

   mmu_dcache_state_e      state_q, state_d;
   logic [ADDR_SIZE-1:0]   miss_addr_q;
   logic [ADDR_SIZE-1:0]   victim_addr_q;
   logic [LANE_SIZE-1:0]   lane_q;
   logic [CNT_SIZE-1:0]    miss_cnt_q;
   logic [CNT_SIZE-1:0]    wb_cnt_q;

   logic                   capture;
   logic                   buf_load;
   lane_src_e              buf_sel;
   logic                   wb_done;
   logic                   fill_done;

   function automatic logic [ADDR_SIZE-1:0] lane_align(input logic [ADDR_SIZE-1:0] addr);
      logic [ADDR_SIZE-1:0] aligned;
      aligned                 = addr;
      aligned[OFF_SIZE-1:0]   = '0;
      return aligned;
   endfunction

   function automatic logic [INDEX_SIZE-1:0] lane_index(input logic [ADDR_SIZE-1:0] addr);
      return addr[OFF_SIZE +: INDEX_SIZE];
   endfunction

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_SIZE-1:0] sat_inc(input logic [CNT_SIZE-1:0] val);
      return (&val) ? val : val + CNT_SIZE'(1);
   endfunction

   segre_mmu_lane_buffer #(
      .LANE_SIZE (LANE_SIZE)
   ) u_lane_buffer (
      .clk_i         (clk_i),
      .rsn_i         (rsn_i),
      .load_i        (buf_load),
      .sel_i         (buf_sel),
      .victim_data_i (victim_data_i),
      .mem_data_i    (mem_rdata_i),
      .data_o        (lane_q)
   );

   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         miss_addr_q   <= '0;
         victim_addr_q <= '0;
      end else if (capture) begin
         miss_addr_q   <= miss_addr_i;
         victim_addr_q <= victim_addr_i;
      end
   end

   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         miss_cnt_q <= '0;
         wb_cnt_q   <= '0;
      end else begin
         if (fill_done) miss_cnt_q <= sat_inc(miss_cnt_q);
         if (wb_done)   wb_cnt_q   <= sat_inc(wb_cnt_q);
      end
   end

   // Next state plus all outputs. Outputs depend on state and registered
   // data only, so nothing flows combinationally from inputs to outputs.
   always_comb begin
      state_d       = state_q;
      capture       = 1'b0;
      buf_load      = 1'b0;
      buf_sel       = LANE_SRC_VICTIM;
      wb_done       = 1'b0;
      fill_done     = 1'b0;
      busy_o        = 1'b0;
      mmu_wr_data_o = 1'b0;
      mmu_index_o   = '0;
      mmu_data_o    = '0;
      mem_wr_o      = 1'b0;
      mem_rd_o      = 1'b0;
      mem_addr_o    = '0;
      mem_data_o    = '0;

      case (state_q)
         IDLE: begin
            if (miss_i) begin
               capture  = 1'b1;
               buf_load = 1'b1;
               state_d  = victim_dirty_i ? WB_REQ : RD_REQ;
            end
         end
         WB_REQ: begin
            busy_o     = 1'b1;
            mem_wr_o   = 1'b1;
            mem_addr_o = lane_align(victim_addr_q);
            mem_data_o = lane_q;
            if (mem_ready_i) begin
               wb_done = 1'b1;
               state_d = RD_REQ;
            end
         end
         RD_REQ: begin
            busy_o     = 1'b1;
            mem_rd_o   = 1'b1;
            mem_addr_o = lane_align(miss_addr_q);
            if (mem_ready_i) state_d = RD_WAIT;
         end
         RD_WAIT: begin
            busy_o = 1'b1;
            if (mem_rvalid_i) begin
               buf_load = 1'b1;
               buf_sel  = LANE_SRC_MEM;
               state_d  = FILL;
            end
         end
         FILL: begin
            busy_o        = 1'b1;
            mmu_wr_data_o = 1'b1;
            mmu_index_o   = lane_index(miss_addr_q);
            mmu_data_o    = lane_q;
            fill_done     = 1'b1;
            state_d       = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign miss_cnt_o = miss_cnt_q;
   assign wb_cnt_o   = wb_cnt_q;

endmodule

// File: tb/tb_segre_mmu_dcache_ctrl.sv
// Testbench for segre_mmu_dcache_ctrl: directed miss scenarios against a
// small memory, with an obligation-based reference model checked every cycle.
module tb_segre_mmu_dcache_ctrl;

   localparam int AW = 32;
   localparam int LW = 128;
   localparam int IW = 6;
   localparam int CW = 4;
   localparam int CMAX = 15;

   logic          clk_i = 1'b0;
   logic          rsn_i = 1'b1;
   logic          miss_i = 1'b0;
   logic [AW-1:0] miss_addr_i = '0;
   logic          victim_dirty_i = 1'b0;
   logic [AW-1:0] victim_addr_i = '0;
   logic [LW-1:0] victim_data_i = '0;
   logic          busy_o;
   logic          mmu_wr_data_o;
   logic [IW-1:0] mmu_index_o;
   logic [LW-1:0] mmu_data_o;
   logic          mem_wr_o;
   logic          mem_rd_o;
   logic [AW-1:0] mem_addr_o;
   logic [LW-1:0] mem_data_o;
   logic          mem_ready_i = 1'b1;
   logic          mem_rvalid_i;
   logic [LW-1:0] mem_rdata_i;
   logic [CW-1:0] miss_cnt_o;
   logic [CW-1:0] wb_cnt_o;

   always #5 clk_i = ~clk_i;

   segre_mmu_dcache_ctrl #(
      .ADDR_SIZE  (AW),
      .LANE_SIZE  (LW),
      .INDEX_SIZE (IW),
      .CNT_SIZE   (CW)
   ) dut (
      .clk_i          (clk_i),
      .rsn_i          (rsn_i),
      .miss_i         (miss_i),
      .miss_addr_i    (miss_addr_i),
      .victim_dirty_i (victim_dirty_i),
      .victim_addr_i  (victim_addr_i),
      .victim_data_i  (victim_data_i),
      .busy_o         (busy_o),
      .mmu_wr_data_o  (mmu_wr_data_o),
      .mmu_index_o    (mmu_index_o),
      .mmu_data_o     (mmu_data_o),
      .mem_wr_o       (mem_wr_o),
      .mem_rd_o       (mem_rd_o),
      .mem_addr_o     (mem_addr_o),
      .mem_data_o     (mem_data_o),
      .mem_ready_i    (mem_ready_i),
      .mem_rvalid_i   (mem_rvalid_i),
      .mem_rdata_i    (mem_rdata_i),
      .miss_cnt_o     (miss_cnt_o),
      .wb_cnt_o       (wb_cnt_o)
   );

   int compared   = 0;
   int mismatched = 0;

   task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [AW-1:0] al(input logic [AW-1:0] a);
      return {a[AW-1:4], 4'h0};
   endfunction

   // ---------------- memory model ----------------
   logic [LW-1:0] mem_model [logic [AW-1:0]];
   logic          auto_rv  = 1'b0;
   logic          stray_rv = 1'b0;
   logic          hold_rv  = 1'b0;
   logic [LW-1:0] rd_q     = '0;
   logic [LW-1:0] junk     = '0;
   int            wb_stall = 0;
   int            rd_stall = 0;

   assign mem_rvalid_i = auto_rv | stray_rv;
   assign mem_rdata_i  = auto_rv ? rd_q : junk;

   // Read data returns one cycle after the read is accepted.
   always @(posedge clk_i) begin : mem_p
      logic          acc;
      logic [LW-1:0] nxt;
      acc = rsn_i && mem_rd_o && mem_ready_i;
      nxt = '0;
      if (rsn_i && mem_wr_o && mem_ready_i) mem_model[mem_addr_o] = mem_data_o;
      if (acc && mem_model.exists(mem_addr_o)) nxt = mem_model[mem_addr_o];
      #1;
      auto_rv = acc && !hold_rv;
      rd_q    = nxt;
      if (mem_wr_o && wb_stall > 0) begin
         mem_ready_i = 1'b0;
         wb_stall--;
      end else if (mem_rd_o && rd_stall > 0) begin
         mem_ready_i = 1'b0;
         rd_stall--;
      end else begin
         mem_ready_i = 1'b1;
      end
   end

   // ---------------- reference model ----------------
   // Tracks outstanding obligations of the current miss rather than states.
   int            cyc = 0;
   bit            m_wb, m_rd, m_wait, m_fill;
   logic [AW-1:0] m_maddr, m_vaddr;
   logic [LW-1:0] m_buf;
   int            m_miss, m_wbc;
   int            cap_cyc = 0;
   int            captures = 0;

   always @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         m_wb = 0; m_rd = 0; m_wait = 0; m_fill = 0;
         m_maddr = '0; m_vaddr = '0; m_buf = '0;
         m_miss = 0; m_wbc = 0;
      end else begin
         cyc++;
         if (!(m_wb || m_rd || m_wait || m_fill)) begin
            if (miss_i) begin
               m_maddr = miss_addr_i;
               m_vaddr = victim_addr_i;
               m_buf   = victim_data_i;
               m_wb    = victim_dirty_i;
               m_rd    = 1;
               cap_cyc = cyc;
               captures++;
            end
         end else if (m_wb) begin
            if (mem_ready_i) begin
               m_wb  = 0;
               m_wbc = (m_wbc >= CMAX) ? CMAX : m_wbc + 1;
            end
         end else if (m_rd) begin
            if (mem_ready_i) begin
               m_rd   = 0;
               m_wait = 1;
            end
         end else if (m_wait) begin
            if (mem_rvalid_i) begin
               m_buf  = mem_rdata_i;
               m_wait = 0;
               m_fill = 1;
            end
         end else begin
            m_fill = 0;
            m_miss = (m_miss >= CMAX) ? CMAX : m_miss + 1;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   int            fills = 0;
   int            fill_cyc = 0;
   logic [LW-1:0] last_fill_data = '0;
   logic [IW-1:0] last_fill_idx = '0;

   always @(negedge clk_i) begin : cmp_p
      bit            e_busy;
      logic [AW-1:0] e_addr;
      e_busy = m_wb || m_rd || m_wait || m_fill;
      e_addr = m_wb ? al(m_vaddr) : (m_rd ? al(m_maddr) : '0);
      chk("busy",     LW'(busy_o),        LW'(e_busy));
      chk("mem_wr",   LW'(mem_wr_o),      LW'(m_wb));
      chk("mem_rd",   LW'(mem_rd_o),      LW'(m_rd && !m_wb));
      chk("mem_addr", LW'(mem_addr_o),    LW'(e_addr));
      chk("mem_data", mem_data_o,         m_wb ? m_buf : '0);
      chk("fill",     LW'(mmu_wr_data_o), LW'(m_fill));
      chk("fill_idx", LW'(mmu_index_o),   m_fill ? LW'(m_maddr[9:4]) : '0);
      chk("fill_dat", mmu_data_o,         m_fill ? m_buf : '0);
      chk("miss_cnt", LW'(miss_cnt_o),    LW'(m_miss));
      chk("wb_cnt",   LW'(wb_cnt_o),      LW'(m_wbc));
      if (mmu_wr_data_o) begin
         fills++;
         fill_cyc       = cyc;
         last_fill_data = mmu_data_o;
         last_fill_idx  = mmu_index_o;
      end
   end

   // ---------------- helpers ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      @(negedge clk_i);
      while (busy_o && n < budget) begin
         @(negedge clk_i);
         n++;
      end
      chk("idle_in_budget", LW'(busy_o), '0);
      step(1);
   endtask

   task automatic start_miss(input logic [AW-1:0] ma, input logic [AW-1:0] va,
                             input logic [LW-1:0] vd, input logic dirty);
      miss_i         = 1'b1;
      miss_addr_i    = ma;
      victim_addr_i  = va;
      victim_data_i  = vd;
      victim_dirty_i = dirty;
      step(1);
      miss_i = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- directed tests ----------------
   initial begin : stim
      int f0, c0;
      #1 rsn_i = 1'b0;
      repeat (2) @(negedge clk_i);
      chk("rst_busy",   LW'(busy_o),        '0);
      chk("rst_wr",     LW'(mem_wr_o),      '0);
      chk("rst_rd",     LW'(mem_rd_o),      '0);
      chk("rst_fill",   LW'(mmu_wr_data_o), '0);
      chk("rst_addr",   LW'(mem_addr_o),    '0);
      chk("rst_misscnt", LW'(miss_cnt_o),   '0);
      chk("rst_wbcnt",  LW'(wb_cnt_o),      '0);
      rsn_i = 1'b1;
      step(1);

      // clean miss
      mem_model[32'h0000_1230] = {16{8'hA5}};
      start_miss(32'h0000_1234, 32'h0000_7700, {4{32'h0BAD_F00D}}, 1'b0);
      chk("t1_rd",   LW'(mem_rd_o),   LW'(1));
      chk("t1_wr",   LW'(mem_wr_o),   '0);
      chk("t1_addr", LW'(mem_addr_o), LW'(32'h0000_1230));
      wait_idle(20);
      chk("t1_lat",  LW'(fill_cyc - cap_cyc + 1), LW'(3));
      chk("t1_data", last_fill_data, {16{8'hA5}});
      chk("t1_idx",  LW'(last_fill_idx), LW'(6'h23));
      chk("t1_miss", LW'(miss_cnt_o), LW'(1));
      chk("t1_wb",   LW'(wb_cnt_o),   LW'(0));

      // dirty miss
      mem_model[32'h0000_3450] = 128'h0123456789ABCDEF_FEDCBA9876543210;
      start_miss(32'h0000_3458, 32'h0000_2230, {4{32'hDEAD_BEEF}}, 1'b1);
      chk("t2_wr",    LW'(mem_wr_o),   LW'(1));
      chk("t2_rd0",   LW'(mem_rd_o),   '0);
      chk("t2_waddr", LW'(mem_addr_o), LW'(32'h0000_2230));
      chk("t2_wdata", mem_data_o,      {4{32'hDEAD_BEEF}});
      step(1);
      chk("t2_rd",    LW'(mem_rd_o),   LW'(1));
      chk("t2_raddr", LW'(mem_addr_o), LW'(32'h0000_3450));
      wait_idle(20);
      chk("t2_lat",   LW'(fill_cyc - cap_cyc + 1), LW'(4));
      chk("t2_data",  last_fill_data, 128'h0123456789ABCDEF_FEDCBA9876543210);
      chk("t2_idx",   LW'(last_fill_idx), LW'(6'h05));
      chk("t2_mem",   mem_model[32'h0000_2230], {4{32'hDEAD_BEEF}});
      chk("t2_wb",    LW'(wb_cnt_o),   LW'(1));
      chk("t2_miss",  LW'(miss_cnt_o), LW'(2));

      // backpressure, refill of the lane just written back
      wb_stall = 5;
      rd_stall = 3;
      start_miss(32'h0000_2234, 32'h0000_2230, {4{32'hCAFE_F00D}}, 1'b1);
      step(3);
      chk("t3_wr_held",   LW'(mem_wr_o),   LW'(1));
      chk("t3_addr_held", LW'(mem_addr_o), LW'(32'h0000_2230));
      chk("t3_data_held", mem_data_o,      {4{32'hCAFE_F00D}});
      wait_idle(40);
      chk("t3_lat",  LW'(fill_cyc - cap_cyc + 1), LW'(12));
      chk("t3_data", last_fill_data, {4{32'hCAFE_F00D}});
      chk("t3_idx",  LW'(last_fill_idx), LW'(6'h23));
      chk("t3_wb",   LW'(wb_cnt_o),   LW'(2));
      chk("t3_miss", LW'(miss_cnt_o), LW'(3));

      // interference: stray rvalid in IDLE and RD_REQ, miss_i toggling
      junk     = {4{32'h1111_1111}};
      stray_rv = 1'b1;
      step(1);
      stray_rv = 1'b0;
      mem_model[32'h0000_4000] = {4{32'h9999_9999}};
      rd_stall = 3;
      f0 = fills;
      c0 = captures;
      start_miss(32'h0000_4000, 32'h0000_5000, {4{32'h7777_7777}}, 1'b1);
      for (int k = 0; k < 3; k++) begin
         miss_i = (k % 2 == 0);
         step(1);
      end
      miss_i   = 1'b0;
      stray_rv = 1'b1;
      step(1);
      stray_rv = 1'b0;
      chk("t4_still_rd", LW'(mem_rd_o), LW'(1));
      wait_idle(30);
      chk("t4_fills", LW'(fills - f0),    LW'(1));
      chk("t4_caps",  LW'(captures - c0), LW'(1));
      chk("t4_data",  last_fill_data, {4{32'h9999_9999}});
      chk("t4_wbmem", mem_model[32'h0000_5000], {4{32'h7777_7777}});
      chk("t4_miss",  LW'(miss_cnt_o), LW'(4));
      chk("t4_wb",    LW'(wb_cnt_o),   LW'(3));

      // back-to-back dirty misses until both counters saturate
      miss_i         = 1'b1;
      miss_addr_i    = 32'h0000_8000;
      victim_addr_i  = 32'h0000_9000;
      victim_data_i  = {4{32'h5A5A_5A5A}};
      victim_dirty_i = 1'b1;
      step(100);
      miss_i = 1'b0;
      wait_idle(20);
      chk("t5_miss_sat", LW'(miss_cnt_o), LW'(CMAX));
      chk("t5_wb_sat",   LW'(wb_cnt_o),   LW'(CMAX));

      // asynchronous reset while waiting for read data
      hold_rv = 1'b1;
      start_miss(32'h0000_6000, 32'h0000_6100, {4{32'h3C3C_3C3C}}, 1'b0);
      step(1);
      chk("t6_busy_pre", LW'(busy_o), LW'(1));
      #2 rsn_i = 1'b0;
      #1;
      chk("t6_busy",  LW'(busy_o),        '0);
      chk("t6_rd",    LW'(mem_rd_o),      '0);
      chk("t6_fill",  LW'(mmu_wr_data_o), '0);
      chk("t6_miss",  LW'(miss_cnt_o),    '0);
      chk("t6_wb",    LW'(wb_cnt_o),      '0);
      hold_rv = 1'b0;
      @(negedge clk_i);
      rsn_i = 1'b1;
      f0 = fills;
      step(10);
      chk("t6_nofill",  LW'(fills - f0),  '0);
      chk("t6_miss_after", LW'(miss_cnt_o), '0);
      chk("t6_idle",    LW'(busy_o),      '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
